// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the instruction/data memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  localparam int unsigned ADDR_W_DEF       = 32;
  localparam int unsigned DATA_W_DEF       = 32;
  localparam int unsigned MAX_D_STREAK_DEF = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Request selection: data wins ties unless the fetch side has been starved long enough.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  logic   streak_full,
  output owner_e sel
);

  always_comb begin
    sel = OWN_NONE;
    if (i_req && (!d_req || streak_full)) sel = OWN_I;
    else if (d_req)                       sel = OWN_D;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between fetch (read-only) and load/store ports,
// one transaction in flight, responses routed back by the registered owner.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned MAX_D_STREAK = MAX_D_STREAK_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                m_req,
  output logic                m_we,
  output logic [DATA_W/8-1:0] m_be,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic                m_rvalid,
  input  logic [DATA_W-1:0]   m_rdata,
  output logic                err
);

  localparam int unsigned SW = $clog2(MAX_D_STREAK + 1);

  owner_e          owner_q, owner_d;
  logic [SW-1:0]   streak_q, streak_d;
  logic            err_q, err_d;
  logic            can_issue, streak_full;
  owner_e          sel;

  assign streak_full = (streak_q == SW'(MAX_D_STREAK));
  // Gated by rst so every output drops the moment reset is asserted.
  assign can_issue   = !rst && ((owner_q == OWN_NONE) || m_rvalid);

  mem_arb_pick u_pick (
    .i_req       (i_req),
    .d_req       (d_req),
    .streak_full (streak_full),
    .sel         (sel)
  );

  assign i_gnt = can_issue && (sel == OWN_I);
  assign d_gnt = can_issue && (sel == OWN_D);
  assign m_req = i_gnt | d_gnt;

  always_comb begin
    m_we    = 1'b0;
    m_be    = '0;
    m_addr  = '0;
    m_wdata = '0;
    if (i_gnt) begin
      m_be   = '1;
      m_addr = i_addr;
    end else if (d_gnt) begin
      m_we    = d_we;
      m_be    = d_be;
      m_addr  = d_addr;
      m_wdata = d_wdata;
    end
  end

  assign i_rvalid = m_rvalid && (owner_q == OWN_I);
  assign d_rvalid = m_rvalid && (owner_q == OWN_D);
  assign i_rdata  = i_rvalid ? m_rdata : '0;
  assign d_rdata  = d_rvalid ? m_rdata : '0;
  assign err      = err_q;

  always_comb begin
    owner_d = owner_q;
    if (i_gnt)         owner_d = OWN_I;
    else if (d_gnt)    owner_d = OWN_D;
    else if (m_rvalid) owner_d = OWN_NONE;
  end

  always_comb begin
    streak_d = streak_q;
    if (d_gnt && i_req)      streak_d = streak_full ? streak_q : streak_q + SW'(1);
    else if (i_gnt || !i_req) streak_d = '0;
  end

  assign err_d = err_q | (m_rvalid && (owner_q == OWN_NONE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q  <= OWN_NONE;
      streak_q <= '0;
      err_q    <= 1'b0;
    end else begin
      owner_q  <= owner_d;
      streak_q <= streak_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: RAM model, transaction-level scoreboard and directed scenarios.
module tb_mem_arbiter;

  localparam int AW = 32, DW = 32, BW = 4, MAXD = 4;

  logic          clk = 1'b0, rst = 1'b1;
  logic          i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [BW-1:0] d_be = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          i_gnt, i_rvalid, d_gnt, d_rvalid, m_req, m_we, m_rvalid, err;
  logic [DW-1:0] i_rdata, d_rdata, m_wdata, m_rdata;
  logic [AW-1:0] m_addr;
  logic [BW-1:0] m_be;

  int errors = 0, checks = 0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(MAXD)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // RAM: answers exactly one cycle after each request; not affected by rst.
  logic [DW-1:0] mem [0:1023];
  logic          mem_rv = 1'b0, inj = 1'b0;
  logic [DW-1:0] mem_rd = '0;
  assign m_rvalid = mem_rv | inj;
  assign m_rdata  = mem_rd;

  always @(posedge clk) begin
    mem_rv <= m_req;
    if (m_req) begin
      mem_rd <= mem[m_addr[11:2]];
      if (m_we)
        for (int b = 0; b < BW; b++)
          if (m_be[b]) mem[m_addr[11:2]][8*b +: 8] <= m_wdata[8*b +: 8];
    end else begin
      mem_rd <= '0;
    end
  end

  // Scoreboard: queue of in-flight owners (1=fetch, 2=data) and a count of
  // data grants made while a fetch was waiting.
  int q[$];
  int dstr = 0;
  bit err_m = 1'b0;

  always @(posedge rst or negedge clk) begin
    bit can, wi, wd, gi, gd, ri, rd;
    if (rst) begin
      q.delete();
      dstr  = 0;
      err_m = 1'b0;
    end else begin
      can = (q.size() == 0) || m_rvalid;
      wi  = i_req && (!d_req || dstr >= MAXD);
      wd  = d_req && !wi;
      gi  = can && wi;
      gd  = can && wd;
      ri  = m_rvalid && (q.size() > 0) && (q[0] == 1);
      rd  = m_rvalid && (q.size() > 0) && (q[0] == 2);
      chk("i_gnt",    64'(i_gnt),    64'(gi));
      chk("d_gnt",    64'(d_gnt),    64'(gd));
      chk("m_req",    64'(m_req),    64'(gi | gd));
      chk("m_we",     64'(m_we),     64'(gd & d_we));
      chk("m_be",     64'(m_be),     64'(gi ? {BW{1'b1}} : gd ? d_be : '0));
      chk("m_addr",   64'(m_addr),   64'(gi ? i_addr : gd ? d_addr : '0));
      if (gd)       chk("m_wdata", 64'(m_wdata), 64'(d_wdata));
      else if (!gi) chk("m_wdata", 64'(m_wdata), 64'(0));
      chk("i_rvalid", 64'(i_rvalid), 64'(ri));
      chk("d_rvalid", 64'(d_rvalid), 64'(rd));
      chk("i_rdata",  64'(i_rdata),  64'(ri ? m_rdata : '0));
      chk("d_rdata",  64'(d_rdata),  64'(rd ? m_rdata : '0));
      chk("err",      64'(err),      64'(err_m));
      if (m_rvalid) begin
        if (q.size() == 0) err_m = 1'b1;
        else void'(q.pop_front());
      end
      if (gi) q.push_back(1);
      if (gd) q.push_back(2);
      if (gd && i_req)      dstr = (dstr < MAXD) ? dstr + 1 : MAXD;
      else if (gi || !i_req) dstr = 0;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    logic [11:0] seq;
    int          ng;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[0]   = 32'h0000_0013;
    mem[1]   = 32'h0000_0093;
    mem[64]  = 32'hCAFE_0001;
    mem[128] = 32'h1234_5678;

    #2;
    chk("rst_m_req",  64'(m_req),  64'(0));
    chk("rst_i_gnt",  64'(i_gnt),  64'(0));
    chk("rst_d_gnt",  64'(d_gnt),  64'(0));
    chk("rst_err",    64'(err),    64'(0));
    #10 rst = 1'b0;
    tick();

    // single fetch
    i_req = 1'b1; i_addr = 32'h8000_0000;
    smp();
    chk("t1_i_gnt",  64'(i_gnt),  64'(1));
    chk("t1_m_addr", 64'(m_addr), 64'h8000_0000);
    chk("t1_m_be",   64'(m_be),   64'hF);
    tick(); i_req = 1'b0;
    smp();
    chk("t1_i_rvalid", 64'(i_rvalid), 64'(1));
    chk("t1_i_rdata",  64'(i_rdata),  64'h13);
    chk("t1_d_rvalid", 64'(d_rvalid), 64'(0));
    tick();

    // simultaneous requests: data first, fetch back-to-back on the response
    i_req = 1'b1; i_addr = 32'h8000_0004;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8000_0100;
    smp();
    chk("t2_d_gnt", 64'(d_gnt), 64'(1));
    chk("t2_i_gnt", 64'(i_gnt), 64'(0));
    tick(); d_req = 1'b0;
    smp();
    chk("t2_d_rvalid", 64'(d_rvalid), 64'(1));
    chk("t2_d_rdata",  64'(d_rdata),  64'hCAFE_0001);
    chk("t2_i_gnt1",   64'(i_gnt),    64'(1));
    tick(); i_req = 1'b0;
    smp();
    chk("t2_i_rvalid", 64'(i_rvalid), 64'(1));
    chk("t2_i_rdata",  64'(i_rdata),  64'h93);
    tick();

    // starvation guard: fetch forced through after MAXD data grants
    seq = '0; ng = 0;
    i_req = 1'b1; i_addr = 32'h8000_0000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8000_0100;
    for (int k = 0; k < 12; k++) begin
      smp();
      if (i_gnt) seq[k] = 1'b1;
      if (i_gnt || d_gnt) ng++;
      tick();
    end
    i_req = 1'b0; d_req = 1'b0;
    smp(); tick();
    chk("t3_seq",    64'(seq), 64'h210);
    chk("t3_grants", 64'(ng),  64'(12));

    // store low half, then read it back merged
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_wdata = 32'hDEAD_BEEF; d_addr = 32'h8000_0200;
    smp();
    chk("t4_m_we",    64'(m_we),    64'(1));
    chk("t4_m_be",    64'(m_be),    64'h3);
    chk("t4_m_wdata", 64'(m_wdata), 64'hDEAD_BEEF);
    tick(); d_req = 1'b0; d_we = 1'b0;
    smp();
    chk("t4_st_ack", 64'(d_rvalid), 64'(1));
    tick(); d_req = 1'b1; d_be = 4'b0000;
    smp();
    chk("t4_ld_gnt", 64'(d_gnt), 64'(1));
    tick(); d_req = 1'b0;
    smp();
    chk("t4_ld_rdata", 64'(d_rdata), 64'h1234_BEEF);
    tick();

    // stray response sets a sticky error
    inj = 1'b1;
    smp();
    chk("t5_err_pre", 64'(err), 64'(0));
    chk("t5_stray_unrouted", 64'(i_rvalid | d_rvalid), 64'(0));
    tick(); inj = 1'b0;
    smp();
    chk("t5_err_set", 64'(err), 64'(1));
    tick(); smp();
    chk("t5_err_sticky", 64'(err), 64'(1));
    tick();

    // reset while a fetch is outstanding
    i_req = 1'b1; i_addr = 32'h8000_0000;
    smp();
    chk("t5_i_gnt", 64'(i_gnt), 64'(1));
    tick(); i_req = 1'b0;
    rst = 1'b1; #1;
    chk("t5_rst_i_rvalid", 64'(i_rvalid), 64'(0));
    chk("t5_rst_i_rdata",  64'(i_rdata),  64'(0));
    chk("t5_rst_m_req",    64'(m_req),    64'(0));
    chk("t5_rst_err",      64'(err),      64'(0));
    #1 rst = 1'b0;
    smp();
    chk("t5_post_err0", 64'(err), 64'(0));
    tick(); smp();
    chk("t5_post_err1", 64'(err), 64'(1));
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
